// File: rtl/round_robin_bus_arbiter.sv
// Round-robin arbiter for three burst requesters feeding
// a one-entry registered valid/ready output stage.
module round_robin_bus_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BEATS  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [2:0]            last,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic [DATA_WIDTH-1:0] data2,
  input  logic                  out_ready,
  output logic [2:0]            grant,
  output logic [1:0]            select,
  output logic [2:0]            ack,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  localparam int CW =
    (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(MAX_BEATS - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            grant_q, grant_d;
  logic [1:0]            sel_q, sel_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ov_q, ov_d;
  logic [DATA_WIDTH-1:0] od_q, od_d;

  logic                  g_req;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  win_vld;
  logic [1:0]            win_sel;
  logic                  capture;
  logic [2:0]            ack_c;
  int                    idx;

  // Steer the granted requester's req/last/data.
  always_comb begin
    g_req  = req[0];
    g_last = last[0];
    g_data = data0;
    case (sel_q)
      2'd1: begin
        g_req  = req[1];
        g_last = last[1];
        g_data = data1;
      end
      2'd2: begin
        g_req  = req[2];
        g_last = last[2];
        g_data = data2;
      end
      default: ;
    endcase
  end

  // First requester at or after ptr, mod 3.
  always_comb begin
    win_vld = 1'b0;
    win_sel = 2'd0;
    idx     = 0;
    for (int k = 2; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= 3) idx = idx - 3;
      if (req[idx]) begin
        win_vld = 1'b1;
        win_sel = 2'(idx);
      end
    end
  end

  // Next-state, capture and output-stage logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    od_d    = od_q;
    capture = 1'b0;
    ack_c   = 3'b000;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = 3'b001 << win_sel;
          sel_d   = win_sel;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        capture = g_req && (!ov_q || out_ready);
        if (capture) begin
          od_d  = g_data;
          cnt_d = cnt_q + 1'b1;
          ack_c = grant_q;
        end
        if (!g_req || (capture &&
            (g_last || cnt_q == CNT_MAX))) begin
          grant_d = 3'b000;
          sel_d   = 2'd0;
          ptr_d   = (sel_q == 2'd2) ? 2'd0
                                    : sel_q + 2'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture)
      ov_d = 1'b1;
    else if (ov_q && out_ready)
      ov_d = 1'b0;
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
    end
  end

  assign ack       = reset ? 3'b000 : ack_c;
  assign grant     = grant_q;
  assign select    = sel_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_round_robin_bus_arbiter.sv
// Directed vector bench for round_robin_bus_arbiter.
// Table of cycle vectors plus hand-written sequences.
module tb_round_robin_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  last;
  logic [15:0] data0, data1, data2;
  logic        out_ready;
  logic [2:0]  grant;
  logic [1:0]  select;
  logic [2:0]  ack;
  logic        out_valid;
  logic [15:0] out_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  last;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        rdy;
    logic [2:0]  eack;
    logic [2:0]  egnt;
    logic        eov;
    logic [15:0] eod;
  } vec_t;

  vec_t tbl[18];

  round_robin_bus_arbiter #(
    .DATA_WIDTH(16),
    .MAX_BEATS (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .last     (last),
    .data0    (data0),
    .data1    (data1),
    .data2    (data2),
    .out_ready(out_ready),
    .grant    (grant),
    .select   (select),
    .ack      (ack),
    .out_valid(out_valid),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(
    logic [2:0] r, logic [2:0] l,
    logic [15:0] a, logic [15:0] b,
    logic [15:0] c, logic y,
    logic [2:0] ea, logic [2:0] eg,
    logic ev, logic [15:0] ed);
    vec_t v;
    v.req = r; v.last = l;
    v.d0 = a; v.d1 = b; v.d2 = c;
    v.rdy = y; v.eack = ea; v.egnt = eg;
    v.eov = ev; v.eod = ed;
    return v;
  endfunction

  task automatic chk(string nm, int id,
                     logic [15:0] act,
                     logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h",
               nm, id, act, exp);
    end
  endtask

  // Drive at negedge, check ack before the edge,
  // check registered outputs #1 after the edge.
  task automatic step(int id, logic rst, vec_t v);
    logic [1:0] esel;
    @(negedge clock);
    reset     = rst;
    req       = v.req;
    last      = v.last;
    data0     = v.d0;
    data1     = v.d1;
    data2     = v.d2;
    out_ready = v.rdy;
    #1;
    chk("ack", id, 16'(ack), 16'(v.eack));
    @(posedge clock);
    #1;
    esel = v.egnt[1] ? 2'd1 :
           v.egnt[2] ? 2'd2 : 2'd0;
    chk("grant", id, 16'(grant), 16'(v.egnt));
    chk("select", id, 16'(select), 16'(esel));
    chk("out_valid", id, 16'(out_valid),
        16'(v.eov));
    chk("out_data", id, out_data, v.eod);
    chk("busy", id, 16'(busy),
        16'(v.egnt != 3'b000));
  endtask

  initial begin
    reset = 1'b1; req = '0; last = '0;
    data0 = '0; data1 = '0; data2 = '0;
    out_ready = 1'b1;

    // single burst of 3 from requester 0
    tbl[0]  = mk(3'b001, 3'b000, 16'h00A0, 0, 0, 1,
                 3'b000, 3'b001, 0, 16'h0000);
    tbl[1]  = mk(3'b001, 3'b000, 16'h00A0, 0, 0, 1,
                 3'b001, 3'b001, 1, 16'h00A0);
    tbl[2]  = mk(3'b001, 3'b000, 16'h00B0, 0, 0, 1,
                 3'b001, 3'b001, 1, 16'h00B0);
    tbl[3]  = mk(3'b001, 3'b001, 16'h00C0, 0, 0, 1,
                 3'b001, 3'b000, 1, 16'h00C0);
    tbl[4]  = mk(3'b000, 3'b000, 16'h00C0, 0, 0, 1,
                 3'b000, 3'b000, 0, 16'h00C0);
    // fairness: all request, 1-beat bursts
    tbl[5]  = mk(3'b111, 3'b111, 16'h10, 16'h11,
                 16'h12, 1,
                 3'b000, 3'b010, 0, 16'h00C0);
    tbl[6]  = mk(3'b111, 3'b111, 16'h10, 16'h11,
                 16'h12, 1,
                 3'b010, 3'b000, 1, 16'h0011);
    tbl[7]  = mk(3'b111, 3'b111, 16'h10, 16'h11,
                 16'h12, 1,
                 3'b000, 3'b100, 0, 16'h0011);
    tbl[8]  = mk(3'b111, 3'b111, 16'h10, 16'h11,
                 16'h12, 1,
                 3'b100, 3'b000, 1, 16'h0012);
    tbl[9]  = mk(3'b111, 3'b111, 16'h10, 16'h11,
                 16'h12, 1,
                 3'b000, 3'b001, 0, 16'h0012);
    tbl[10] = mk(3'b111, 3'b111, 16'h10, 16'h11,
                 16'h12, 1,
                 3'b001, 3'b000, 1, 16'h0010);
    tbl[11] = mk(3'b000, 3'b000, 0, 0, 0, 1,
                 3'b000, 3'b000, 0, 16'h0010);
    // abort: requester 1 drops req after 1 beat
    tbl[12] = mk(3'b010, 3'b000, 0, 16'h55, 0, 1,
                 3'b000, 3'b010, 0, 16'h0010);
    tbl[13] = mk(3'b010, 3'b000, 0, 16'h55, 0, 1,
                 3'b010, 3'b010, 1, 16'h0055);
    tbl[14] = mk(3'b000, 3'b000, 0, 16'h55, 0, 1,
                 3'b000, 3'b000, 0, 16'h0055);
    // ptr now 2: requester 2 wins
    tbl[15] = mk(3'b111, 3'b111, 16'h10, 16'h11,
                 16'h12, 1,
                 3'b000, 3'b100, 0, 16'h0055);
    tbl[16] = mk(3'b111, 3'b111, 16'h10, 16'h11,
                 16'h12, 1,
                 3'b100, 3'b000, 1, 16'h0012);
    tbl[17] = mk(3'b000, 3'b000, 0, 0, 0, 1,
                 3'b000, 3'b000, 0, 16'h0012);

    // reset state, requests ignored while in reset
    step(0, 1'b1, mk(3'b111, 3'b111, 1, 2, 3, 1,
                     3'b000, 3'b000, 0, 16'h0));
    step(1, 1'b1, mk(3'b111, 3'b111, 1, 2, 3, 1,
                     3'b000, 3'b000, 0, 16'h0));

    for (int i = 0; i < 18; i++)
      step(100 + i, 1'b0, tbl[i]);

    // MAX_BEATS cap: req0 with no last, req1 waiting
    step(200, 0, mk(3'b011, 0, 16'h1, 16'h77, 0, 1,
                    3'b000, 3'b001, 0, 16'h0012));
    for (int b = 1; b <= 4; b++)
      step(200 + b, 0,
           mk(3'b011, 0, 16'(b), 16'h77, 0, 1,
              3'b001, (b == 4) ? 3'b000 : 3'b001,
              1, 16'(b)));
    step(205, 0, mk(3'b011, 0, 16'h5, 16'h77, 0, 1,
                    3'b000, 3'b010, 0, 16'h0004));
    step(206, 0, mk(3'b011, 3'b010, 16'h5, 16'h77,
                    0, 1,
                    3'b010, 3'b000, 1, 16'h0077));
    step(207, 0, mk(3'b011, 0, 16'h5, 16'h77, 0, 1,
                    3'b000, 3'b001, 0, 16'h0077));
    step(208, 0, mk(3'b011, 0, 16'h5, 16'h77, 0, 1,
                    3'b001, 3'b001, 1, 16'h0005));
    step(209, 0, mk(3'b011, 3'b001, 16'h6, 16'h77,
                    0, 1,
                    3'b001, 3'b000, 1, 16'h0006));
    step(210, 0, mk(3'b000, 0, 0, 0, 0, 1,
                    3'b000, 3'b000, 0, 16'h0006));

    // backpressure mid-burst on requester 1
    step(300, 0, mk(3'b010, 0, 0, 16'hA1, 0, 1,
                    3'b000, 3'b010, 0, 16'h0006));
    step(301, 0, mk(3'b010, 0, 0, 16'hA1, 0, 1,
                    3'b010, 3'b010, 1, 16'h00A1));
    for (int s = 0; s < 3; s++)
      step(302 + s, 0,
           mk(3'b010, 0, 0, 16'hA2, 0, 0,
              3'b000, 3'b010, 1, 16'h00A1));
    step(305, 0, mk(3'b010, 0, 0, 16'hA2, 0, 1,
                    3'b010, 3'b010, 1, 16'h00A2));
    step(306, 0, mk(3'b010, 3'b010, 0, 16'hA3, 0, 1,
                    3'b010, 3'b000, 1, 16'h00A3));
    step(307, 0, mk(3'b000, 0, 0, 0, 0, 1,
                    3'b000, 3'b000, 0, 16'h00A3));

    // reset mid-burst with a held beat
    step(400, 0, mk(3'b100, 0, 0, 0, 16'hBB, 0,
                    3'b000, 3'b100, 0, 16'h00A3));
    step(401, 0, mk(3'b100, 0, 0, 0, 16'hBB, 0,
                    3'b100, 3'b100, 1, 16'h00BB));
    step(402, 1, mk(3'b100, 0, 0, 0, 16'hCC, 0,
                    3'b000, 3'b000, 0, 16'h0000));
    // ptr back to 0: requester 0 wins
    step(403, 0, mk(3'b111, 3'b111, 16'hD0, 16'hD1,
                    16'hD2, 1,
                    3'b000, 3'b001, 0, 16'h0000));
    step(404, 0, mk(3'b111, 3'b111, 16'hD0, 16'hD1,
                    16'hD2, 1,
                    3'b001, 3'b000, 1, 16'h00D0));

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
